// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence playback unit:
// state codes, board-clock timing defaults, ROM widths.
package exibe_sequencia_pkg;

  localparam int T_ON_DEF   = 500;
  localparam int T_OFF_DEF  = 250;
  localparam int N_END_DEF  = 4;
  localparam int N_DADO_DEF = 4;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    BUSCA   = 4'd1,
    CARREGA = 4'd2,
    ACENDE  = 4'd3,
    APAGA   = 4'd4,
    FIM     = 4'd5
  } estado_t;

endpackage

// File: rtl/exibe_sequencia_contador.sv
// contador_m: modulo-M counter, sync clear (clr low or zera), enable conta.
// Ports: clock, clr, zera, conta in; fim out (high when count is M-1).
module contador_m #(
  parameter int M = 500
) (
  input  logic clock,
  input  logic clr,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] q;

  always_ff @(posedge clock) begin
    if (!clr || zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == W'(M - 1)) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/exibe_sequencia.sv
// Replays ROM entries 0..ultimo on the LEDs (T_ON lit, T_OFF dark each).
// Ports: clock, clr, iniciar, parar, ultimo, dado in; endereco, leds, ocupado, pronto, db_estado out.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ON   = T_ON_DEF,
  parameter int T_OFF  = T_OFF_DEF,
  parameter int N_END  = N_END_DEF,
  parameter int N_DADO = N_DADO_DEF
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [N_END-1:0]  ultimo,
  input  logic [N_DADO-1:0] dado,
  output logic [N_END-1:0]  endereco,
  output logic [N_DADO-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  estado_t estado;
  logic    fim_on;
  logic    fim_off;

  // Each timer is held at zero outside its own state, so it
  // starts from 0 on the first cycle of ACENDE/APAGA.
  contador_m #(.M(T_ON)) u_timer_on (
    .clock (clock),
    .clr   (clr),
    .zera  (estado != ACENDE),
    .conta (estado == ACENDE),
    .fim   (fim_on)
  );

  contador_m #(.M(T_OFF)) u_timer_off (
    .clock (clock),
    .clr   (clr),
    .zera  (estado != APAGA),
    .conta (estado == APAGA),
    .fim   (fim_off)
  );

  always_ff @(posedge clock) begin
    if (!clr) begin
      estado   <= OCIOSO;
      endereco <= '0;
      leds     <= '0;
    end else if (parar && estado != OCIOSO) begin
      estado <= OCIOSO;
      leds   <= '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (iniciar && !parar) begin
            estado   <= BUSCA;
            endereco <= '0;
          end
        end
        BUSCA: estado <= CARREGA;
        CARREGA: begin
          leds   <= dado;
          estado <= ACENDE;
        end
        ACENDE: begin
          if (fim_on) begin
            leds   <= '0;
            estado <= APAGA;
          end
        end
        APAGA: begin
          // End test first so ultimo = all-ones never wraps.
          if (fim_off) begin
            if (endereco == ultimo) begin
              estado <= FIM;
            end else begin
              endereco <= endereco + 1'b1;
              estado   <= BUSCA;
            end
          end
        end
        FIM: estado <= OCIOSO;
        default: begin
          estado <= OCIOSO;
          leds   <= '0;
        end
      endcase
    end
  end

  assign ocupado   = (estado != OCIOSO);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: sync ROM model plus timing-rule reference.
// Ports: none; drives clock/clr/iniciar/parar/ultimo and checks all outputs.
module tb_exibe_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int P     = 2 + T_ON + T_OFF;

  typedef struct packed {
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db;
  } obs_t;

  logic       clock = 1'b0;
  logic       clr;
  logic       iniciar;
  logic       parar;
  logic [3:0] ultimo;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  obs_t       obs;
  int         total = 0;
  int         bad   = 0;

  exibe_sequencia #(
    .T_ON   (T_ON),
    .T_OFF  (T_OFF),
    .N_END  (4),
    .N_DADO (4)
  ) dut (
    .clock     (clock),
    .clr       (clr),
    .iniciar   (iniciar),
    .parar     (parar),
    .ultimo    (ultimo),
    .dado      (dado),
    .endereco  (endereco),
    .leds      (leds),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) dado <= mem[endereco];

  assign obs = {endereco, leds, ocupado, pronto, db_estado};

  // Expected outputs t cycles after the edge that sampled iniciar,
  // derived from the per-entry slot layout: fetch, load, lit, dark.
  function automatic obs_t model(input int t, input int u);
    obs_t e;
    int   i;
    int   ph;
    e  = '0;
    i  = t / P;
    ph = t % P;
    if (t > P * (u + 1)) begin
      e.endereco = 4'(u);
    end else if (i == u + 1) begin
      e.endereco = 4'(u);
      e.ocupado  = 1'b1;
      e.pronto   = 1'b1;
      e.db       = 4'd5;
    end else begin
      e.endereco = 4'(i);
      e.ocupado  = 1'b1;
      if (ph == 0) e.db = 4'd1;
      else if (ph == 1) e.db = 4'd2;
      else if (ph < 2 + T_ON) begin
        e.db   = 4'd3;
        e.leds = mem[i];
      end else e.db = 4'd4;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      int r;
      r = int'($urandom_range(0, 4));
      mem[i] = (r == 4) ? 4'd0 : 4'(1 << r);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    iniciar = 1'b1;
    parar = 1'b0;
    ultimo = 4'd0;
    tick();
    tick();
    total++;
    if (obs !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset got=%h want=%h", obs, obs_t'(0));
    end
    clr = 1'b1;
    iniciar = 1'b0;
    tick();
    total++;
    if (obs !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", obs, obs_t'(0));
    end
  endtask

  task automatic test_idle_priority();
    ultimo = 4'd3;
    iniciar = 1'b1;
    parar = 1'b1;
    tick();
    iniciar = 1'b0;
    parar = 1'b0;
    total++;
    if (obs !== obs_t'(0)) begin
      bad++;
      $display("FAIL parar_wins got=%h want=%h", obs, obs_t'(0));
    end
  endtask

  task automatic test_replay(input string nm, input int u, input int busy_t);
    obs_t e;
    int   n;
    n = P * (u + 1) + 3;
    ultimo = 4'(u);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int t = 0; t <= n; t++) begin
      e = model(t, u);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s t=%0d got=%h want=%h", nm, t, obs, e);
      end
      iniciar = (t == busy_t);
      tick();
    end
    iniciar = 1'b0;
  endtask

  task automatic test_abort();
    obs_t e;
    obs_t held;
    int   ta;
    ta = 2 * P + 2 + T_ON;
    ultimo = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int t = 0; t <= ta; t++) begin
      e = model(t, 3);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL abort_run t=%0d got=%h want=%h", t, obs, e);
      end
      tick();
    end
    parar = 1'b1;
    tick();
    parar = 1'b0;
    held = '0;
    held.endereco = 4'd2;
    for (int t = 0; t < 6; t++) begin
      total++;
      if (obs !== held) begin
        bad++;
        $display("FAIL abort_idle t=%0d got=%h want=%h", t, obs, held);
      end
      tick();
    end
    test_replay("restart", 1, -1);
  endtask

  task automatic test_reset_mid();
    obs_t e;
    ultimo = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int t = 0; t <= P + 3; t++) begin
      e = model(t, 3);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL rstmid_run t=%0d got=%h want=%h", t, obs, e);
      end
      tick();
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    for (int t = 0; t < 5; t++) begin
      total++;
      if (obs !== obs_t'(0)) begin
        bad++;
        $display("FAIL rstmid_idle t=%0d got=%h want=%h", t, obs, obs_t'(0));
      end
      tick();
    end
  endtask

  initial begin
    mem[0] = 4'd1;
    mem[1] = 4'd2;
    mem[2] = 4'd4;
    mem[3] = 4'd8;
    for (int i = 4; i < 16; i++) mem[i] = 4'd0;
    test_reset();
    test_idle_priority();
    test_replay("single", 0, -1);
    test_replay("full", 3, -1);
    test_replay("busy", 3, P + 3);
    test_abort();
    test_reset_mid();
    mem[2] = 4'd0;
    test_replay("dark", 3, -1);
    fill_random();
    test_replay("wrap16", 15, -1);
    for (int k = 0; k < 5; k++) begin
      fill_random();
      test_replay("random", int'($urandom_range(0, 7)), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Playback side of the memory game. Replays the stored sequence to the player: reads ROM entries 0..ultimo, lights each one on the LEDs for T_ON cycles, then blanks them for T_OFF cycles.
- Sits beside the play-checking datapath (sequence/address counters, ROM, button comparators).
- Drives the game ROM address while active; the game control unit arbitrates ROM ownership through `ocupado`.
- The unit starts playback with `iniciar` and waits for `pronto` before enabling player input.

Parameters:
- T_ON, 500: cycles each LED stays lit (500 ms at 1 kHz clock).
- T_OFF, 250: blank cycles after each LED.
- N_END, 4: ROM address width.
- N_DADO, 4: ROM data / LED width.

Ports:
- clock  in  1  system clock, rising edge.
- clr  in  1  synchronous active-low reset.
- iniciar  in  1  start playback; sampled only in OCIOSO.
- parar  in  1  synchronous abort; returns to OCIOSO without `pronto`.
- ultimo  in  N_END  index of the last entry to play (current sequence length minus 1).
- dado  in  N_DADO  ROM data_out (synchronous ROM, 1-cycle read latency).
- endereco  out  N_END  ROM address.
- leds  out  N_DADO  one-hot LED drive; 0 when blank.
- ocupado  out  1  high in every state except OCIOSO.
- pronto  out  1  one-cycle pulse after the last entry's T_OFF.
- db_estado  out  4  state code for debug displays.

Behaviour:
- Reset (clr=0 at an edge): state OCIOSO, endereco=0, leds=0, ocupado=0, pronto=0, timer=0. Reset wins over every other input, including mid-playback.
- All outputs are registered. `ocupado` and `pronto` are decoded from the registered state.
- States and codes:
  - OCIOSO=0: iniciar=1 → BUSCA, endereco←0.
  - BUSCA=1: one cycle; the address is being registered by the ROM → CARREGA.
  - CARREGA=2: one cycle; dado is now valid for endereco. At the exit edge: leds←dado, timer←0 → ACENDE.
  - ACENDE=3: timer counts. When timer=T_ON-1: leds←0, timer←0 → APAGA.
  - APAGA=4: timer counts. When timer=T_OFF-1:
    - if endereco==ultimo → FIM;
    - else endereco←endereco+1 → BUSCA.
  - FIM=5: pronto=1 for exactly this cycle → OCIOSO. endereco holds its final value.
- Timing:
  - iniciar sampled at edge k → leds show entry 0 from edge k+2 through edge k+2+T_ON.
  - Per-entry period = 2+T_ON+T_OFF cycles.
  - pronto asserts (ultimo+1)·(2+T_ON+T_OFF) cycles after edge k, for 1 cycle.
- iniciar while ocupado=1: ignored, no restart.
- parar=1 in any state other than OCIOSO: next edge gives OCIOSO, leds=0, no pronto, endereco held.
- parar and iniciar both high in OCIOSO: parar wins, stay idle.
- ultimo=0: exactly one entry played.
- ultimo=2^N_END-1: all 16 entries played; the increment never wraps because the end test precedes it.
- ultimo sampled continuously; it must be stable while ocupado=1. Changing it mid-playback is outside spec.
- dado=0 (blank ROM word): played as a dark slot; timing is unchanged.
- Timer width = clog2(max(T_ON,T_OFF)). T_ON and T_OFF must each be ≥1.

Decomposition:
- Shared package/include:
  - state code localparams (OCIOSO..FIM);
  - default T_ON/T_OFF for the 1 kHz board clock;
  - N_END/N_DADO defaults shared with the datapath.
- Sub-module: reuse contador_m as the on/off timer, zeroed on state entry and enabled in ACENDE/APAGA.
  - Its fim output replaces the inline compare.
  - Instantiate two copies (M=T_ON, M=T_OFF) or one copy sized to the max with an explicit terminal compare.
- FSM (next-state plus registered outputs) and the address register stay in this module.

Test Plan (T_ON=4, T_OFF=2, behavioural sync ROM with mem[0..3]=1,2,4,8):
- Single entry: ultimo=0, iniciar pulse at edge k → leds=0001 for edges k+2..k+5, 0 for 2 cycles; pronto high 1 cycle at k+8; ocupado low after.
- Full replay: ultimo=3 → leds sequence 1,2,4,8, each 4 cycles with 2 blank between; endereco 0→3; pronto at k+32; endereco remains 3.
- Busy guard: second iniciar during ACENDE of entry 1 → no restart, same trace as the full-replay scenario.
- Abort: parar during APAGA of entry 2 → next cycle OCIOSO, leds=0, ocupado=0, pronto never asserted. A fresh iniciar then restarts from endereco=0.
- Reset mid-op: clr=0 for 1 cycle during ACENDE → all outputs 0, db_estado=0. No activity until iniciar.
- Wrap/16 entries: 16-word ROM, ultimo=15 → 16 slots played, endereco ends at 15 (no wrap to 0); pronto after 16·8 cycles.
